// File: rtl/spi_cfg_pkg.sv
// spi_cfg_pkg: shared constants, register map and pin-FSM states for the SPI config controller
package spi_cfg_pkg;
  localparam int FRAME_W = 16;
  localparam logic WRITE_BIT = 1'b1;
  localparam int MAX_ADDR = 4;
  localparam logic [6:0] EN_OUT_LO = 7'd0;
  localparam logic [6:0] EN_OUT_HI = 7'd1;
  localparam logic [6:0] EN_PWM_LO = 7'd2;
  localparam logic [6:0] EN_PWM_HI = 7'd3;
  localparam logic [6:0] PWM_DUTY = 7'd4;
  typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, HOLD, GAP} state_t;
endpackage

// File: rtl/spi_frame_shifter.sv
// spi_frame_shifter: serialises one 16-bit frame onto sclk/copi/ncs with slow, synchroniser-friendly timing
module spi_frame_shifter import spi_cfg_pkg::*; #(
  parameter int CLK_DIV = 4,
  parameter int SETUP_CYC = 4,
  parameter int HOLD_CYC = 4,
  parameter int GAP_CYC = 4
)(
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic [FRAME_W-1:0] frame,
  output logic busy,
  output logic done,
  output logic sclk,
  output logic copi,
  output logic ncs
);
  state_t state, state_n;
  logic [7:0] cnt, cnt_n;
  logic [3:0] bcnt, bcnt_n;
  logic [FRAME_W-1:0] sr, sr_n;
  logic tc;
  assign tc = cnt == 8'd0;
  assign busy = state != IDLE;
  assign sclk = state == HIGH;
  assign ncs = state == IDLE || state == GAP;
  assign copi = !ncs && sr[FRAME_W-1];
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      bcnt <= '0;
      sr <= '0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      bcnt <= bcnt_n;
      sr <= sr_n;
      done <= state == HOLD && tc;
    end
  end
  // the shift happens on leaving HIGH so copi only moves while sclk is low
  always_comb begin
    state_n = state;
    cnt_n = tc ? cnt : cnt - 8'd1;
    bcnt_n = bcnt;
    sr_n = sr;
    unique case (state)
      IDLE: if (start) begin
        state_n = SETUP;
        cnt_n = 8'(SETUP_CYC - 1);
        bcnt_n = 4'd15;
        sr_n = frame;
      end
      SETUP: if (tc) begin
        state_n = HIGH;
        cnt_n = 8'(CLK_DIV - 1);
      end
      HIGH: if (tc) begin
        state_n = bcnt == 4'd0 ? HOLD : LOW;
        cnt_n = 8'(bcnt == 4'd0 ? HOLD_CYC - 1 : CLK_DIV - 1);
        bcnt_n = bcnt == 4'd0 ? bcnt : bcnt - 4'd1;
        sr_n = bcnt == 4'd0 ? sr : {sr[FRAME_W-2:0], 1'b0};
      end
      LOW: if (tc) begin
        state_n = HIGH;
        cnt_n = 8'(CLK_DIV - 1);
      end
      HOLD: if (tc) begin
        state_n = GAP;
        cnt_n = 8'(GAP_CYC - 1);
      end
      GAP: if (tc) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: rtl/spi_cfg_controller.sv
// spi_cfg_controller: round-robin arbiter over two register-write requesters feeding one SPI frame shifter
module spi_cfg_controller import spi_cfg_pkg::WRITE_BIT; #(
  parameter int CLK_DIV = 4,
  parameter int CS_SETUP = 4,
  parameter int CS_HOLD = 4,
  parameter int GAP = 4,
  parameter int MAX_ADDR = spi_cfg_pkg::MAX_ADDR
)(
  input  logic clk,
  input  logic rst,
  input  logic req0_valid,
  input  logic [6:0] req0_addr,
  input  logic [7:0] req0_data,
  output logic req0_ready,
  input  logic req1_valid,
  input  logic [6:0] req1_addr,
  input  logic [7:0] req1_data,
  output logic req1_ready,
  output logic sclk,
  output logic copi,
  output logic ncs,
  output logic busy,
  output logic done,
  output logic done_id,
  output logic err,
  output logic err_id
);
  logic sel, acc, bad, last_grant;
  logic [6:0] addr;
  logic [7:0] data;
  assign sel = req0_valid && req1_valid ? !last_grant : req1_valid;
  assign req0_ready = !rst && !busy && req0_valid && !sel;
  assign req1_ready = !rst && !busy && req1_valid && sel;
  assign acc = req0_ready || req1_ready;
  assign addr = sel ? req1_addr : req0_addr;
  assign data = sel ? req1_data : req0_data;
  assign bad = addr > 7'(MAX_ADDR);
  // rejected requests still rotate priority so a faulty requester cannot starve the other
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
      done_id <= 1'b0;
      err <= 1'b0;
      err_id <= 1'b0;
    end else begin
      err <= acc && bad;
      if (acc) last_grant <= sel;
      if (acc && bad) err_id <= sel;
      if (acc && !bad) done_id <= sel;
    end
  end
  spi_frame_shifter #(
    .CLK_DIV(CLK_DIV),
    .SETUP_CYC(CS_SETUP),
    .HOLD_CYC(CS_HOLD),
    .GAP_CYC(GAP)
  ) u_shift (
    .clk(clk),
    .rst(rst),
    .start(acc && !bad),
    .frame({WRITE_BIT, addr, data}),
    .busy(busy),
    .done(done),
    .sclk(sclk),
    .copi(copi),
    .ncs(ncs)
  );
endmodule
